// File: rtl/req_frame_assembler_pkg.sv
// Shared definitions for the request frame assembler:
// widths, header layout, engine select, FSM states, helpers.
package req_frame_assembler_pkg;

    localparam int ADDRW_DEF   = 24;
    localparam int OPCODEW_DEF = 2;
    localparam int TIMEOUT_DEF = 255;

    // opcode[0] selects the engine whose ready gates the transfer
    localparam logic ENG_AES = 1'b0;
    localparam logic ENG_SHA = 1'b1;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_KEY   = 3'd1,
        ST_TEXT  = 3'd2,
        ST_DEST  = 3'd3,
        ST_ISSUE = 3'd4
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int addr_bytes(input int addrw);
        return (addrw + 7) / 8;
    endfunction

    function automatic int instrw(input int addrw, input int opw);
        return 3 * addrw + opw;
    endfunction

    // header bits above the opcode are reserved and must be zero
    function automatic logic [7:0] hdr_rsvd_mask(input int opw);
        return 8'hFF << opw;
    endfunction

endpackage

// File: rtl/req_frame_assembler_frame_gap_timer.sv
// Idle-gap timer: counts enabled cycles since the last clear and
// flags expiry on the cycle the count would reach TIMEOUT.
module frame_gap_timer
    import req_frame_assembler_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CWR = clog2(TIMEOUT + 1);
    localparam int CW  = (CWR < 1) ? 1 : CWR;
    localparam logic [CW-1:0] LIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] SAT = CW'(TIMEOUT);

    logic [CW-1:0] r_cnt;

    // saturating gap counter, clear has priority over counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != SAT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // depends only on state and count so it can gate in_ready safely
    assign o_expired = (TIMEOUT != 0) && i_enable && (r_cnt == LIM);

endmodule

// File: rtl/req_frame_assembler.sv
// Assembles header/key/text/dest byte frames into one request and
// issues it to the queue under per-engine backpressure.
module req_frame_assembler
    import req_frame_assembler_pkg::*;
#(
    parameter int ADDRW   = ADDRW_DEF,
    parameter int OPCODEW = OPCODEW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               ready_aes,
    input  logic               ready_sha,
    output logic               valid_out,
    output logic [OPCODEW-1:0] opcode,
    output logic [ADDRW-1:0]   key_addr,
    output logic [ADDRW-1:0]   text_addr,
    output logic [ADDRW-1:0]   dest_addr,
    output logic               frame_err,
    output logic               busy
);

    localparam int NB  = addr_bytes(ADDRW);
    localparam int BCR = clog2(NB);
    localparam int BCW = (BCR < 1) ? 1 : BCR;
    localparam logic [BCW-1:0] BC_LAST = BCW'(NB - 1);
    localparam logic [7:0]     RSVD    = hdr_rsvd_mask(OPCODEW);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BCW-1:0]     r_bcnt;
    logic [BCW-1:0]     w_bcnt_nxt;
    logic [OPCODEW-1:0] r_op;
    logic [ADDRW-1:0]   r_key;
    logic [ADDRW-1:0]   r_text;
    logic [ADDRW-1:0]   r_dest;
    logic               r_hdr_err;

    logic w_in_ready;
    logic w_accept;
    logic w_field;
    logic w_expired;
    logic w_tgt_rdy;
    logic w_hdr_ok;
    logic w_hdr_bad;
    logic w_valid;

    assign w_field   = (r_state == ST_KEY) || (r_state == ST_TEXT) ||
                       (r_state == ST_DEST);
    assign w_accept  = in_valid && w_in_ready;
    assign w_tgt_rdy = (r_op[0] == ENG_SHA) ? ready_sha : ready_aes;

    frame_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap (
        .clk       (clk),
        .rst       (rst),
        .i_enable  (w_field),
        .i_clear   (w_accept || !w_field),
        .o_expired (w_expired)
    );

    // state and byte-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_HDR;
            r_bcnt    <= '0;
            r_hdr_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bcnt    <= w_bcnt_nxt;
            r_hdr_err <= w_hdr_bad;
        end
    end

    // next state, handshake and issue control
    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_in_ready  = 1'b0;
        w_valid     = 1'b0;
        w_hdr_ok    = 1'b0;
        w_hdr_bad   = 1'b0;
        unique case (r_state)
            ST_HDR: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    if ((in_data & RSVD) != 8'd0) begin
                        w_hdr_bad = 1'b1;
                    end else begin
                        w_hdr_ok    = 1'b1;
                        w_bcnt_nxt  = '0;
                        w_state_nxt = ST_KEY;
                    end
                end
            end
            ST_KEY, ST_TEXT, ST_DEST: begin
                w_in_ready = !w_expired;
                if (w_expired) begin
                    w_bcnt_nxt  = '0;
                    w_state_nxt = ST_HDR;
                end else if (in_valid) begin
                    if (r_bcnt == BC_LAST) begin
                        w_bcnt_nxt = '0;
                        if (r_state == ST_KEY) begin
                            w_state_nxt = ST_TEXT;
                        end else if (r_state == ST_TEXT) begin
                            w_state_nxt = ST_DEST;
                        end else begin
                            w_state_nxt = ST_ISSUE;
                        end
                    end else begin
                        w_bcnt_nxt = r_bcnt + BCW'(1);
                    end
                end
            end
            ST_ISSUE: begin
                w_valid = 1'b1;
                if (w_tgt_rdy) begin
                    w_state_nxt = ST_HDR;
                end
            end
            default: begin
                w_state_nxt = ST_HDR;
            end
        endcase
    end

    // field registers shift in MSB byte first; excess high bits fall off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= '0;
            r_key  <= '0;
            r_text <= '0;
            r_dest <= '0;
        end else if (w_accept) begin
            if (w_hdr_ok) begin
                r_op <= in_data[OPCODEW-1:0];
            end
            if (r_state == ST_KEY) begin
                r_key <= (r_key << 8) | ADDRW'(in_data);
            end
            if (r_state == ST_TEXT) begin
                r_text <= (r_text << 8) | ADDRW'(in_data);
            end
            if (r_state == ST_DEST) begin
                r_dest <= (r_dest << 8) | ADDRW'(in_data);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign valid_out = w_valid;
    assign opcode    = r_op;
    assign key_addr  = r_key;
    assign text_addr = r_text;
    assign dest_addr = r_dest;
    assign frame_err = r_hdr_err | w_expired;
    assign busy      = (r_state != ST_HDR);

endmodule

// File: tb/tb_req_frame_assembler.sv
// Self-checking bench for req_frame_assembler: default instance A and
// a 20-bit-address, TIMEOUT=4 instance B, each with a scoreboard.
module tb_req_frame_assembler;

    typedef struct packed {
        logic [1:0]  op;
        logic [23:0] key;
        logic [23:0] text;
        logic [23:0] dest;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  a_in_data;
    logic        a_in_valid, a_in_ready, a_rdy_aes, a_rdy_sha;
    logic        a_valid, a_err, a_busy;
    logic [1:0]  a_op;
    logic [23:0] a_key, a_text, a_dest;

    logic [7:0]  b_in_data;
    logic        b_in_valid, b_in_ready, b_rdy_aes, b_rdy_sha;
    logic        b_valid, b_err, b_busy;
    logic [1:0]  b_op;
    logic [19:0] b_key, b_text, b_dest;

    frame_t q_a[$];
    frame_t q_b[$];
    int n_chk  = 0;
    int n_pass = 0;

    req_frame_assembler u_a (
        .clk(clk), .rst(rst),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .ready_aes(a_rdy_aes), .ready_sha(a_rdy_sha),
        .valid_out(a_valid), .opcode(a_op),
        .key_addr(a_key), .text_addr(a_text), .dest_addr(a_dest),
        .frame_err(a_err), .busy(a_busy)
    );

    req_frame_assembler #(.ADDRW(20), .OPCODEW(2), .TIMEOUT(4)) u_b (
        .clk(clk), .rst(rst),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .ready_aes(b_rdy_aes), .ready_sha(b_rdy_sha),
        .valid_out(b_valid), .opcode(b_op),
        .key_addr(b_key), .text_addr(b_text), .dest_addr(b_dest),
        .frame_err(b_err), .busy(b_busy)
    );

    // scoreboard A: sampled 1ns before each rising edge
    always begin : mon_a
        frame_t e;
        @(negedge clk);
        #4;
        if (a_valid === 1'b1) begin
            if (q_a.size() == 0) begin
                n_chk++;
                $display("FAIL a_unexpected_valid: got valid_out=1 key=%h, required no pending frame", a_key);
            end else if ((q_a[0].op[0] ? a_rdy_sha : a_rdy_aes) === 1'b1) begin
                e = q_a.pop_front();
                n_chk++;
                if ({a_op, a_key, a_text, a_dest} !== {e.op, e.key, e.text, e.dest})
                    $display("FAIL a_frame: got op=%h key=%h text=%h dest=%h, required op=%h key=%h text=%h dest=%h",
                             a_op, a_key, a_text, a_dest, e.op, e.key, e.text, e.dest);
                else
                    n_pass++;
            end
        end
    end

    // scoreboard B
    always begin : mon_b
        frame_t e;
        @(negedge clk);
        #4;
        if (b_valid === 1'b1) begin
            if (q_b.size() == 0) begin
                n_chk++;
                $display("FAIL b_unexpected_valid: got valid_out=1 key=%h, required no pending frame", b_key);
            end else if ((q_b[0].op[0] ? b_rdy_sha : b_rdy_aes) === 1'b1) begin
                e = q_b.pop_front();
                n_chk++;
                if ({b_op, 4'h0, b_key, 4'h0, b_text, 4'h0, b_dest} !== {e.op, e.key, e.text, e.dest})
                    $display("FAIL b_frame: got op=%h key=%h text=%h dest=%h, required op=%h key=%h text=%h dest=%h",
                             b_op, b_key, b_text, b_dest, e.op, e.key, e.text, e.dest);
                else
                    n_pass++;
            end
        end
    end

    task automatic a_send(input logic [7:0] b);
        int k;
        k = 0;
        a_in_data  = b;
        a_in_valid = 1'b1;
        while (a_in_ready !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) begin
            n_chk++;
            $display("FAIL a_send_timeout: in_ready stuck at %b, required 1", a_in_ready);
        end
        @(negedge clk);
    endtask

    task automatic b_send(input logic [7:0] b);
        int k;
        k = 0;
        b_in_data  = b;
        b_in_valid = 1'b1;
        while (b_in_ready !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) begin
            n_chk++;
            $display("FAIL b_send_timeout: in_ready stuck at %b, required 1", b_in_ready);
        end
        @(negedge clk);
    endtask

    task automatic a_frame(input logic [1:0] op, input logic [23:0] k,
                           input logic [23:0] t, input logic [23:0] d);
        a_send({6'd0, op});
        a_send(k[23:16]); a_send(k[15:8]); a_send(k[7:0]);
        a_send(t[23:16]); a_send(t[15:8]); a_send(t[7:0]);
        a_send(d[23:16]); a_send(d[15:8]); a_send(d[7:0]);
    endtask

    task automatic b_frame(input logic [7:0] hdr, input logic [23:0] k,
                           input logic [23:0] t, input logic [23:0] d);
        b_send(hdr);
        b_send(k[23:16]); b_send(k[15:8]); b_send(k[7:0]);
        b_send(t[23:16]); b_send(t[15:8]); b_send(t[7:0]);
        b_send(d[23:16]); b_send(d[15:8]); b_send(d[7:0]);
    endtask

    task automatic drain_a();
        int k;
        k = 0;
        while (q_a.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (q_a.size() != 0)
            $display("FAIL a_drain: got %0d frames pending, required 0", q_a.size());
        else
            n_pass++;
    endtask

    task automatic drain_b();
        int k;
        k = 0;
        while (q_b.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (q_b.size() != 0)
            $display("FAIL b_drain: got %0d frames pending, required 0", q_b.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        n_chk++;
        if (a_in_ready !== 1'b1) $display("FAIL rst_a_in_ready: got %b, required 1", a_in_ready);
        else n_pass++;
        n_chk++;
        if (a_valid !== 1'b0) $display("FAIL rst_a_valid: got %b, required 0", a_valid);
        else n_pass++;
        n_chk++;
        if (a_err !== 1'b0) $display("FAIL rst_a_err: got %b, required 0", a_err);
        else n_pass++;
        n_chk++;
        if (a_busy !== 1'b0) $display("FAIL rst_a_busy: got %b, required 0", a_busy);
        else n_pass++;
        n_chk++;
        if ({a_op, a_key, a_text, a_dest} !== 74'd0)
            $display("FAIL rst_a_fields: got %h/%h/%h/%h, required all 0", a_op, a_key, a_text, a_dest);
        else n_pass++;
        n_chk++;
        if ({b_in_ready, b_busy, b_valid} !== 3'b100)
            $display("FAIL rst_b: got in_ready/busy/valid=%b%b%b, required 100", b_in_ready, b_busy, b_valid);
        else n_pass++;
    endtask

    task automatic test_sha_frame();
        a_rdy_sha = 1'b1;
        a_rdy_aes = 1'b0;
        q_a.push_back('{2'd1, 24'h112233, 24'h445566, 24'h778899});
        a_frame(2'd1, 24'h112233, 24'h445566, 24'h778899);
        a_in_valid = 1'b0;
        n_chk++;
        if (a_valid !== 1'b1) $display("FAIL sha_latency: got valid_out=%b, required 1", a_valid);
        else n_pass++;
        n_chk++;
        if (a_in_ready !== 1'b0) $display("FAIL sha_issue_ready: got in_ready=%b, required 0", a_in_ready);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({a_valid, a_busy, a_in_ready} !== 3'b001)
            $display("FAIL sha_after: got valid/busy/in_ready=%b%b%b, required 001", a_valid, a_busy, a_in_ready);
        else n_pass++;
    endtask

    task automatic test_stall();
        a_rdy_aes = 1'b0;
        a_rdy_sha = 1'b1;
        q_a.push_back('{2'd0, 24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3});
        a_frame(2'd0, 24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3);
        a_in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            n_chk++;
            if ({a_valid, a_in_ready, a_key, a_text, a_dest} !==
                {1'b1, 1'b0, 24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3})
                $display("FAIL stall_hold[%0d]: got valid=%b in_ready=%b key=%h text=%h dest=%h, required 1 0 a1a2a3 b1b2b3 c1c2c3",
                         i, a_valid, a_in_ready, a_key, a_text, a_dest);
            else n_pass++;
            @(negedge clk);
        end
        a_rdy_aes = 1'b1;
        @(negedge clk);
        n_chk++;
        if (a_valid !== 1'b0) $display("FAIL stall_release: got valid_out=%b, required 0", a_valid);
        else n_pass++;
    endtask

    task automatic test_bad_header();
        a_rdy_aes = 1'b1;
        a_rdy_sha = 1'b1;
        a_send(8'h81);
        a_in_valid = 1'b0;
        n_chk++;
        if ({a_err, a_busy} !== 2'b10)
            $display("FAIL badhdr_pulse: got err/busy=%b%b, required 10", a_err, a_busy);
        else n_pass++;
        n_chk++;
        if ({a_op, a_key} !== {2'd0, 24'hA1A2A3})
            $display("FAIL badhdr_fields: got op=%h key=%h, required 0 a1a2a3", a_op, a_key);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (a_err !== 1'b0) $display("FAIL badhdr_single: got err=%b, required 0", a_err);
        else n_pass++;
        q_a.push_back('{2'd3, 24'h010203, 24'h040506, 24'h070809});
        a_frame(2'd3, 24'h010203, 24'h040506, 24'h070809);
        a_in_valid = 1'b0;
        drain_a();
    endtask

    task automatic test_addrw20();
        b_rdy_sha = 1'b1;
        b_rdy_aes = 1'b0;
        q_b.push_back('{2'd1, 24'h012345, 24'h0ABCDE, 24'h0FFFFF});
        b_frame(8'h01, 24'hF12345, 24'h0ABCDE, 24'hFFFFFF);
        b_in_valid = 1'b0;
        n_chk++;
        if (b_key !== 20'h12345) $display("FAIL addrw20_key: got %h, required 12345", b_key);
        else n_pass++;
        drain_b();
    endtask

    task automatic test_timeout();
        b_rdy_aes = 1'b1;
        b_send(8'h01);
        b_send(8'h11); b_send(8'h22); b_send(8'h33);
        b_send(8'h44);
        b_in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            n_chk++;
            if ({b_err, b_busy, b_in_ready} !== 3'b011)
                $display("FAIL tmo_idle[%0d]: got err/busy/in_ready=%b%b%b, required 011", i, b_err, b_busy, b_in_ready);
            else n_pass++;
            @(negedge clk);
        end
        n_chk++;
        if ({b_err, b_busy, b_in_ready} !== 3'b110)
            $display("FAIL tmo_fire: got err/busy/in_ready=%b%b%b, required 110", b_err, b_busy, b_in_ready);
        else n_pass++;
        b_in_data  = 8'h03;
        b_in_valid = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({b_err, b_busy, b_in_ready} !== 3'b001)
            $display("FAIL tmo_after: got err/busy/in_ready=%b%b%b, required 001", b_err, b_busy, b_in_ready);
        else n_pass++;
        q_b.push_back('{2'd3, 24'h0ABCDE, 24'h012345, 24'h06789A});
        b_frame(8'h03, 24'h0ABCDE, 24'h012345, 24'h06789A);
        b_in_valid = 1'b0;
        drain_b();
    endtask

    task automatic test_reset_issue();
        a_rdy_aes = 1'b0;
        a_rdy_sha = 1'b0;
        q_a.push_back('{2'd1, 24'h0DEAD0, 24'h0BEEF0, 24'h0CAFE0});
        a_frame(2'd1, 24'h0DEAD0, 24'h0BEEF0, 24'h0CAFE0);
        a_in_valid = 1'b0;
        n_chk++;
        if (a_valid !== 1'b1) $display("FAIL rsti_issue: got valid_out=%b, required 1", a_valid);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if ({a_valid, a_busy} !== 2'b00)
            $display("FAIL rsti_async: got valid/busy=%b%b, required 00", a_valid, a_busy);
        else n_pass++;
        if (q_a.size() != 0) void'(q_a.pop_front());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if ({a_in_ready, a_valid, a_op, a_key, a_dest} !== {1'b1, 1'b0, 2'd0, 24'd0, 24'd0})
            $display("FAIL rsti_release: got in_ready=%b valid=%b op=%h key=%h dest=%h, required 1 0 0 0 0",
                     a_in_ready, a_valid, a_op, a_key, a_dest);
        else n_pass++;
        a_rdy_aes = 1'b1;
        a_rdy_sha = 1'b1;
        q_a.push_back('{2'd0, 24'h102030, 24'h405060, 24'h708090});
        q_a.push_back('{2'd1, 24'hAABBCC, 24'hDDEEFF, 24'h001122});
        q_a.push_back('{2'd2, 24'h334455, 24'h667788, 24'h99AABB});
        a_frame(2'd0, 24'h102030, 24'h405060, 24'h708090);
        a_frame(2'd1, 24'hAABBCC, 24'hDDEEFF, 24'h001122);
        a_frame(2'd2, 24'h334455, 24'h667788, 24'h99AABB);
        a_in_valid = 1'b0;
        drain_a();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        a_in_data  = 8'h00;
        a_in_valid = 1'b0;
        a_rdy_aes  = 1'b0;
        a_rdy_sha  = 1'b0;
        b_in_data  = 8'h00;
        b_in_valid = 1'b0;
        b_rdy_aes  = 1'b0;
        b_rdy_sha  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_sha_frame();
        test_stall();
        test_bad_header();
        test_addrw20();
        test_timeout();
        test_reset_issue();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
